uartlite_axi_sequencer: RTL and testbench
=========================================

Name: uartlite_axi_sequencer

Overview:
- Single AXI4-Lite master that sequences one axi_uartlite core.
- Polls STAT (0x8), drains RX FIFO (0x0) into a 1-byte output register, and pushes bytes from a valid/ready source into TX FIFO (0x4).
- Issues a one-shot FIFO reset through CTRL (0xC) after reset.
- Sits between a UART Lite instance and byte-stream logic (NMEA parser, bridge, forwarder); one instance per UART.

Parameters:
- POLL_GAP, 4: idle cycles between consecutive STAT reads when the previous poll found nothing to do (0 = back-to-back).
- INIT_CTRL, 8'h03: value written to CTRL after reset (bit0 = reset TX FIFO, bit1 = reset RX FIFO).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- AW_addr  out  4  write address, 4'hC (CTRL) or 4'h4 (TX).
- AW_valid  out  1  write address valid.
- AW_ready  in  1  write address ready.
- W_data  out  32  write data, {24'b0, byte}.
- W_valid  out  1  write data valid.
- W_ready  in  1  write data ready.
- B_resp  in  2  write response.
- B_valid  in  1  write response valid.
- B_ready  out  1  write response ready.
- AR_addr  out  4  read address, 4'h8 (STAT) or 4'h0 (RX).
- AR_valid  out  1  read address valid.
- AR_ready  in  1  read address ready.
- R_data  in  32  read data.
- R_resp  in  2  read response.
- R_valid  in  1  read data valid.
- R_ready  out  1  read data ready.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data valid; held until accepted.
- tx_ready  out  1  one-cycle pulse: tx_data accepted (B handshake done).
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data valid; held until rx_ready.
- rx_ready  in  1  consumer accepts rx_data.
- busy  out  1  high in every state except IDLE and GAP.

Behaviour:
- Reset: all AXI valid/ready outputs 0, addresses 0, W_data 0, tx_ready 0, rx_valid 0, rx_data 0, busy 0. FSM enters INIT_AW.
- Reset asserted mid-transaction aborts immediately. No completion is attempted; the slave is reset by the same signal.
- States: INIT_AW -> INIT_B -> IDLE -> STAT_AR -> STAT_R -> {RX_AR -> RX_R | TX_AW -> TX_B | GAP} -> IDLE.
- Write phase (INIT_AW, TX_AW):
  - AW_valid and W_valid assert together on state entry.
  - Each drops independently the cycle after its own ready handshake.
  - The state advances once both handshakes have completed, in any order or the same cycle.
- INIT_AW writes INIT_CTRL to 4'hC.
- INIT_B, TX_B: B_ready = 1 until B_valid; then go to IDLE.
- Read phase (STAT_AR/RX_AR): AR_valid held until AR_ready. In STAT_R/RX_R, R_ready = 1 until R_valid; R_data is captured that cycle.
- IDLE always moves to STAT_AR the next cycle.
- Decision at the STAT_R handshake, with stat = R_data[7:0]:
  - rx_possible = stat[0] && !rx_valid.
  - tx_possible = !stat[3] && tx_valid.
  - Both possible: serve the opposite of last_served (1-bit register, reset = TX, so RX wins first).
  - Only one possible: serve it.
  - Neither: GAP.
- RX_R: rx_data <= R_data[7:0], rx_valid <= 1, last_served <= RX.
- rx_valid clears on the cycle rx_valid && rx_ready. New data is never captured while rx_valid = 1, so no byte is dropped or overwritten.
- TX_AW writes {24'b0, tx_data} to 4'h4. tx_data is sampled at the STAT_R decision and held in a register.
- tx_ready pulses for 1 cycle on the TX_B handshake; last_served <= TX.
- GAP: counts POLL_GAP cycles, then returns to IDLE. POLL_GAP = 0 skips GAP.
- A non-OKAY response (B_resp or R_resp != 2'b00) is treated as OKAY for sequencing. RX data is still delivered.
- Outstanding transactions: at most one; read and write channels are never active simultaneously.
- Minimum RX latency (ready slave): STAT_AR to rx_valid = 4 cycles.

Optional Feature:
- Macro: UARTLITE_SEQ_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt [7:0].
  - Reset to 0; increments on every B or R handshake whose resp != 2'b00.
  - Saturates at 8'hFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset release, slave always ready -> first transaction is AW_addr = 4'hC, W_data = 32'h3, B_ready handshake. Then AR_addr = 4'h8 appears; no AR before the B handshake.
- STAT returns 32'h1, RX returns 32'h24, rx_ready = 1 -> rx_data = 8'h24, rx_valid high for exactly 1 cycle. Next AR is STAT.
- tx_valid = 1, tx_data = 8'h41, STAT = 32'h0 -> AW_addr = 4'h4, W_data = 32'h41. tx_ready pulses once, after B_valid.
- STAT = 32'h1 and tx_valid = 1 on three consecutive polls, rx_ready = 1 -> service order RX, TX, RX.
- STAT = 32'h8 (TX full), tx_valid = 1 -> no AW issued. GAP of POLL_GAP = 4 cycles between STAT reads; tx_ready stays 0.
- rx_valid held (rx_ready = 0), STAT = 32'h1 repeatedly -> no RX read is issued and rx_data stays stable. With UARTLITE_SEQ_ERR_CNT_EN, R_resp = 2'b10 on a STAT read -> err_cnt = 1.

Source files
------------

// File: rtl/uartlite_axi_sequencer.sv
// AXI4-Lite master that sequences one axi_uartlite core: polls STAT, drains RX, feeds TX.
// Define UARTLITE_SEQ_ERR_CNT_EN to add the err_cnt output (saturating non-OKAY response count).
module uartlite_axi_sequencer #(
    parameter int         POLL_GAP  = 4,
    parameter logic [7:0] INIT_CTRL = 8'h03
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  AW_addr,
    output logic        AW_valid,
    input  logic        AW_ready,
    output logic [31:0] W_data,
    output logic        W_valid,
    input  logic        W_ready,
    input  logic [1:0]  B_resp,
    input  logic        B_valid,
    output logic        B_ready,
    output logic [3:0]  AR_addr,
    output logic        AR_valid,
    input  logic        AR_ready,
    input  logic [31:0] R_data,
    input  logic [1:0]  R_resp,
    input  logic        R_valid,
    output logic        R_ready,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy
`ifdef UARTLITE_SEQ_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [3:0] {
        S_INIT_AW, S_INIT_B, S_IDLE, S_STAT_AR, S_STAT_R,
        S_RX_AR, S_RX_R, S_TX_AW, S_TX_B, S_GAP
    } state_t;

    state_t           state;
    logic             aw_done;
    logic             w_done;
    logic             last_rx;
    logic [GAP_W-1:0] gap_cnt;

    logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic       aw_fin, w_fin;
    logic [7:0] stat;
    logic       rx_possible, tx_possible, pick_rx;

    always_comb begin
        aw_hs       = AW_valid && AW_ready;
        w_hs        = W_valid && W_ready;
        b_hs        = B_valid && B_ready;
        ar_hs       = AR_valid && AR_ready;
        r_hs        = R_valid && R_ready;
        aw_fin      = aw_done || aw_hs;
        w_fin       = w_done || w_hs;
        stat        = R_data[7:0];
        rx_possible = stat[0] && !rx_valid;
        tx_possible = !stat[3] && tx_valid;
        // On a tie, serve whichever side did not go last.
        pick_rx     = rx_possible && (!tx_possible || !last_rx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_INIT_AW;
            AW_addr  <= '0;
            AW_valid <= 1'b0;
            W_data   <= '0;
            W_valid  <= 1'b0;
            B_ready  <= 1'b0;
            AR_addr  <= '0;
            AR_valid <= 1'b0;
            R_ready  <= 1'b0;
            tx_ready <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            last_rx  <= 1'b0;
            gap_cnt  <= '0;
        end else begin
            tx_ready <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                S_INIT_AW, S_TX_AW: begin
                    busy <= 1'b1;
                    if (aw_hs) begin
                        AW_valid <= 1'b0;
                        aw_done  <= 1'b1;
                    end
                    if (w_hs) begin
                        W_valid <= 1'b0;
                        w_done  <= 1'b1;
                    end
                    // Coming out of reset the CTRL write has not been launched yet.
                    if (state == S_INIT_AW && !aw_done && !w_done && !AW_valid && !W_valid) begin
                        AW_addr  <= 4'hC;
                        W_data   <= {24'b0, INIT_CTRL};
                        AW_valid <= 1'b1;
                        W_valid  <= 1'b1;
                    end else if (aw_fin && w_fin) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        B_ready <= 1'b1;
                        state   <= (state == S_INIT_AW) ? S_INIT_B : S_TX_B;
                    end
                end

                S_INIT_B, S_TX_B: begin
                    if (b_hs) begin
                        B_ready <= 1'b0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                        if (state == S_TX_B) begin
                            tx_ready <= 1'b1;
                            last_rx  <= 1'b0;
                        end
                    end
                end

                S_IDLE: begin
                    busy     <= 1'b1;
                    AR_addr  <= 4'h8;
                    AR_valid <= 1'b1;
                    state    <= S_STAT_AR;
                end

                S_STAT_AR, S_RX_AR: begin
                    if (ar_hs) begin
                        AR_valid <= 1'b0;
                        R_ready  <= 1'b1;
                        state    <= (state == S_STAT_AR) ? S_STAT_R : S_RX_R;
                    end
                end

                S_STAT_R: begin
                    if (r_hs) begin
                        R_ready <= 1'b0;
                        if (pick_rx) begin
                            AR_addr  <= 4'h0;
                            AR_valid <= 1'b1;
                            state    <= S_RX_AR;
                        end else if (tx_possible) begin
                            AW_addr  <= 4'h4;
                            W_data   <= {24'b0, tx_data};
                            AW_valid <= 1'b1;
                            W_valid  <= 1'b1;
                            state    <= S_TX_AW;
                        end else begin
                            busy    <= 1'b0;
                            gap_cnt <= '0;
                            state   <= (POLL_GAP == 0) ? S_IDLE : S_GAP;
                        end
                    end
                end

                S_RX_R: begin
                    if (r_hs) begin
                        R_ready  <= 1'b0;
                        rx_data  <= R_data[7:0];
                        rx_valid <= 1'b1;
                        last_rx  <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UARTLITE_SEQ_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (((b_hs && B_resp != 2'b00) || (r_hs && R_resp != 2'b00)) && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    logic unused_in;
    assign unused_in = ^R_data[31:8];
`else
    // Responses do not affect sequencing; only the low byte of read data matters.
    logic unused_in;
    assign unused_in = ^{R_data[31:8], R_resp, B_resp};
`endif

endmodule

// File: tb/tb_uartlite_axi_sequencer.sv
// Randomized bench: a UART-Lite-like AXI4-Lite slave, byte producer/consumer,
// and a transaction-level reference model of the polling/arbitration rules.
`timescale 1ns/1ps
module tb_uartlite_axi_sequencer;
    localparam int         GAP  = 4;
    localparam logic [7:0] INIT = 8'h03;
    localparam int OP_INIT = 0, OP_STAT = 1, OP_RX = 2, OP_TX = 3;
    localparam int CYC_PER_PHASE = 1200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  AW_addr;
    logic        AW_valid;
    logic        AW_ready = 1'b0;
    logic [31:0] W_data;
    logic        W_valid;
    logic        W_ready = 1'b0;
    logic [1:0]  B_resp = 2'b00;
    logic        B_valid = 1'b0;
    logic        B_ready;
    logic [3:0]  AR_addr;
    logic        AR_valid;
    logic        AR_ready = 1'b0;
    logic [31:0] R_data = '0;
    logic [1:0]  R_resp = 2'b00;
    logic        R_valid = 1'b0;
    logic        R_ready;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        busy;
`ifdef UARTLITE_SEQ_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    always #5 clk = ~clk;

    uartlite_axi_sequencer #(.POLL_GAP(GAP), .INIT_CTRL(INIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .AW_addr  (AW_addr),
        .AW_valid (AW_valid),
        .AW_ready (AW_ready),
        .W_data   (W_data),
        .W_valid  (W_valid),
        .W_ready  (W_ready),
        .B_resp   (B_resp),
        .B_valid  (B_valid),
        .B_ready  (B_ready),
        .AR_addr  (AR_addr),
        .AR_valid (AR_valid),
        .AR_ready (AR_ready),
        .R_data   (R_data),
        .R_resp   (R_resp),
        .R_valid  (R_valid),
        .R_ready  (R_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .busy     (busy)
`ifdef UARTLITE_SEQ_ERR_CNT_EN
        , .err_cnt (err_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stimulus knobs (percentages)
    int k_rdy, k_rsp, k_tx, k_rxr, k_err, k_stat_rx, k_stat_full;
    bit use_fix;
    logic [31:0] stat_fix;

    // Reference model
    int         op;
    bit         m_held;
    logic [7:0] m_byte;
    bit         m_last_rx;
    int         m_err;
    bit         exp_txr;
    logic [7:0] m_tx_byte;
    int         idle_c;
    int         idle_target;
    int         launch;
    int         polls;
    int         svc_log[$];

    // Slave bookkeeping
    bit         rd_busy;
    logic [3:0] rd_addr;
    bit         aw_got, w_got;
    bit         hs_ar, hs_r, hs_aw, hs_w, hs_b;

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    function automatic logic [1:0] pick_resp();
        return pct(k_err) ? 2'(1 + $urandom_range(2)) : 2'b00;
    endfunction

    task automatic set_phase(input int ph);
        use_fix = 0; stat_fix = '0; k_err = 0; k_stat_rx = 50; k_stat_full = 30;
        case (ph)
            0: begin k_rdy = 100; k_rsp = 100; k_tx = 30;  k_rxr = 50;  end
            1: begin k_rdy = 50;  k_rsp = 40;  k_tx = 30;  k_rxr = 30;  end
            2: begin k_rdy = 100; k_rsp = 100; k_tx = 100; k_rxr = 100; use_fix = 1; stat_fix = 32'h1; end
            3: begin k_rdy = 70;  k_rsp = 70;  k_tx = 100; k_rxr = 100; use_fix = 1; stat_fix = 32'h8; end
            4: begin k_rdy = 70;  k_rsp = 70;  k_tx = 0;   k_rxr = 0;   use_fix = 1; stat_fix = 32'h1; end
            default: begin k_rdy = 60; k_rsp = 60; k_tx = 40; k_rxr = 50; k_err = 30; end
        endcase
    endtask

    // Called at a falling edge; asserts reset wherever the DUT happens to be.
    task automatic do_reset();
        rst = 1'b1;
        AW_ready = 0; W_ready = 0; B_valid = 0; B_resp = 0;
        AR_ready = 0; R_valid = 0; R_data = 0; R_resp = 0;
        tx_valid = 0; tx_data = 0; rx_ready = 0;
        #1;
        check_val("rst_ctl", 32'({AW_valid, W_valid, B_ready, AR_valid, R_ready, tx_ready, rx_valid, busy}), 32'd0);
        check_val("rst_addr", 32'({AW_addr, AR_addr}), 32'd0);
        check_val("rst_wdata", W_data, 32'd0);
        check_val("rst_rxdata", 32'(rx_data), 32'd0);
`ifdef UARTLITE_SEQ_ERR_CNT_EN
        check_val("rst_err", 32'(err_cnt), 32'd0);
`endif
        repeat (3) @(negedge clk);
        op = OP_INIT; m_held = 0; m_byte = 0; m_last_rx = 0; m_err = 0; exp_txr = 0;
        idle_target = -1; idle_c = 0; launch = 3;
        rd_busy = 0; aw_got = 0; w_got = 0;
        hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
        rst = 1'b0;
    endtask

    task automatic cycle();
        bit         held_pre;
        bit         rxp, txp;
        logic [7:0] s;
        @(negedge clk);
        check_val("rx_valid", 32'(rx_valid), 32'(m_held));
        if (m_held) check_val("rx_data", 32'(rx_data), 32'(m_byte));
        check_val("tx_ready", 32'(tx_ready), 32'(exp_txr));
        check_val("one_channel", 32'((AR_valid || R_ready) && (AW_valid || W_valid || B_ready)), 32'd0);
`ifdef UARTLITE_SEQ_ERR_CNT_EN
        check_val("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
        if (launch == 1) check_val("rx_launch", 32'({AR_valid, AR_addr}), 32'({1'b1, 4'h0}));
        if (launch >= 2) check_val("wr_launch", 32'({AW_valid, W_valid}), 32'd3);
        launch = 0;
        if (idle_target >= 0) begin
            idle_c++;
            if (idle_c < idle_target) begin
                check_val("poll_idle", 32'({busy, AR_valid}), 32'd0);
            end else begin
                check_val("poll_start", 32'({busy, AR_valid, AR_addr}), 32'({2'b11, 4'h8}));
                idle_target = -1;
            end
        end

        // Producer / consumer
        if (exp_txr) tx_valid = 1'b0;
        exp_txr = 0;
        if (!tx_valid && pct(k_tx)) begin
            tx_valid = 1'b1;
            tx_data  = 8'($urandom);
        end
        rx_ready = pct(k_rxr);

        // Slave
        if (hs_r) R_valid = 1'b0;
        if (hs_b) B_valid = 1'b0;
        AR_ready = !rd_busy && pct(k_rdy);
        AW_ready = !aw_got && pct(k_rdy);
        W_ready  = !w_got && pct(k_rdy);
        if (rd_busy && !R_valid && pct(k_rsp)) begin
            R_valid = 1'b1;
            R_resp  = pick_resp();
            R_data  = $urandom;
            if (rd_addr == 4'h8) begin
                if (use_fix) R_data = stat_fix;
                else begin
                    R_data[0] = pct(k_stat_rx);
                    R_data[3] = pct(k_stat_full);
                end
            end
        end
        if (aw_got && w_got && !B_valid && pct(k_rsp)) begin
            B_valid = 1'b1;
            B_resp  = pick_resp();
        end

        // Events at the coming rising edge
        hs_ar = AR_valid && AR_ready;
        hs_r  = R_valid && R_ready;
        hs_aw = AW_valid && AW_ready;
        hs_w  = W_valid && W_ready;
        hs_b  = B_valid && B_ready;
        held_pre = m_held;
        if (m_held && rx_ready) m_held = 0;

        if (hs_ar) begin
            check_val("ar_addr", 32'(AR_addr), (op == OP_STAT) ? 32'h8 : (op == OP_RX) ? 32'h0 : 32'hF);
            rd_busy = 1;
            rd_addr = AR_addr;
        end
        if (hs_r) begin
            rd_busy = 0;
            if (R_resp != 2'b00 && m_err < 255) m_err++;
            if (rd_addr == 4'h8) begin
                polls++;
                s   = R_data[7:0];
                rxp = s[0] && !held_pre;
                txp = !s[3] && tx_valid;
                if (rxp && (!txp || !m_last_rx)) begin
                    op = OP_RX; launch = 1; svc_log.push_back(1);
                end else if (txp) begin
                    op = OP_TX; m_tx_byte = tx_data; launch = 2; svc_log.push_back(2);
                end else begin
                    op = OP_STAT; idle_c = 0; idle_target = GAP + 2; svc_log.push_back(0);
                end
            end else begin
                m_held = 1; m_byte = R_data[7:0]; m_last_rx = 1;
                op = OP_STAT; idle_c = 0; idle_target = 2;
            end
        end
        if (hs_aw) begin
            check_val("aw_addr", 32'(AW_addr), (op == OP_INIT) ? 32'hC : (op == OP_TX) ? 32'h4 : 32'hF);
            aw_got = 1;
        end
        if (hs_w) begin
            check_val("w_data", W_data, (op == OP_INIT) ? {24'b0, INIT} :
                                        (op == OP_TX)   ? {24'b0, m_tx_byte} : 32'hFFFF_FFFF);
            w_got = 1;
        end
        if (hs_b) begin
            aw_got = 0; w_got = 0;
            if (B_resp != 2'b00 && m_err < 255) m_err++;
            if (op == OP_TX) begin
                exp_txr   = 1;
                m_last_rx = 0;
            end
            op = OP_STAT; idle_c = 0; idle_target = 2;
        end
    endtask

    initial begin
        int n_tx;
        @(negedge clk);
        for (int ph = 0; ph < 6; ph++) begin
            set_phase(ph);
            if (ph == 0 || ph == 2 || ph == 5) begin
                if (ph != 0) @(negedge clk);
                do_reset();
            end
            polls = 0;
            svc_log.delete();
            repeat (CYC_PER_PHASE) cycle();
            check_val("progress", 32'(polls > 0), 32'd1);
            if (ph == 2) begin
                check_val("order", (svc_log.size() >= 3) ? 32'(svc_log[0] * 100 + svc_log[1] * 10 + svc_log[2]) : 32'd0,
                          32'd121);
            end
            if (ph == 3) begin
                n_tx = 0;
                foreach (svc_log[i]) if (svc_log[i] == 2) n_tx++;
                check_val("full_no_tx", 32'(n_tx), 32'd0);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
